tsc_monitor: RTL and testbench

- Conflict and sequence monitor, acting as the safety receiver for the traffic signal controller's lamp outputs.
- Samples the four 3-bit lamp buses (nl, sl, el, wl) and checks for invalid codes, conflicting approaches, illegal colour sequences, short yellows and a stalled controller.
- On any violation it latches a fault, reports sticky cause bits and drives a flash-enable used to force all-red flashing downstream.
- Sits between tsc and the lamp drivers / board LEDs.

---
 rtl/tsc_pkg.sv | 32 +++
 rtl/tsc_lamp_filter.sv | 72 +++++++
 rtl/tsc_monitor.sv | 149 ++++++++++++++
 tb/tb_tsc_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// tsc_pkg: definitions shared between the traffic signal controller and its
// safety monitor.
//   LAMP_*      one-hot lamp codes used on every approach bus
//   mon_state_t monitor state encoding
//   FC_*        bit positions inside fault_code
//   legal_step  the only colour transitions allowed in normal operation
package tsc_pkg;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_MON   = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    localparam int FC_W         = 5;
    localparam int FC_INVALID   = 0;
    localparam int FC_CONFLICT  = 1;
    localparam int FC_SEQ       = 2;
    localparam int FC_SHORT_YEL = 3;
    localparam int FC_STUCK     = 4;

    function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
        return ((from == LAMP_G) && (to == LAMP_Y)) ||
               ((from == LAMP_Y) && (to == LAMP_R)) ||
               ((from == LAMP_R) && (to == LAMP_G));
    endfunction

endpackage

// File: rtl/tsc_lamp_filter.sv
// tsc_lamp_filter: glitch filter and stable-colour tracker for one approach.
//   clk, rst        clock, async active-high reset
//   clr             clears run and yellow counters (stable colour is kept)
//   lamp            registered lamp code for this approach
//   stable_nxt      stable colour after this edge (includes a same-edge accept)
//   acc             a new valid colour is accepted on this edge
//   inv             a non-one-hot code has been held GLITCH_CYC samples
//   seq_bad         the accept is not a legal colour step
//   short_yel       the accept leaves yellow before MIN_YEL cycles
module tsc_lamp_filter
    import tsc_pkg::*;
#(
    parameter int GLITCH_CYC = 2,
    parameter int MIN_YEL    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [2:0] lamp,
    output logic [2:0] stable_nxt,
    output logic       acc,
    output logic       inv,
    output logic       seq_bad,
    output logic       short_yel
);

    localparam int GW = $clog2(GLITCH_CYC) + 1;
    localparam int YW = $clog2(MIN_YEL) + 1;
    localparam logic [GW-1:0] G_MAX = GW'(GLITCH_CYC);
    localparam logic [YW-1:0] Y_MAX = YW'(MIN_YEL);

    logic [2:0]    cand;
    logic [2:0]    stable;
    logic [GW-1:0] run_cnt, run_nxt;
    logic [YW-1:0] ycnt;
    logic          held;

    always_comb begin
        // run_cnt == 0 means no history (after reset or clear): start a new run
        if ((lamp == cand) && (run_cnt != '0))
            run_nxt = (run_cnt < G_MAX) ? run_cnt + GW'(1) : run_cnt;
        else
            run_nxt = GW'(1);
        held       = (run_nxt >= G_MAX);
        acc        = held && $onehot(lamp) && (lamp != stable);
        inv        = held && !$onehot(lamp);
        stable_nxt = acc ? lamp : stable;
        seq_bad    = acc && !legal_step(stable, lamp);
        short_yel  = acc && (stable == LAMP_Y) && (ycnt < Y_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand    <= LAMP_R;
            stable  <= LAMP_R;
            run_cnt <= '0;
            ycnt    <= '0;
        end else if (clr) begin
            run_cnt <= '0;
            ycnt    <= '0;
        end else begin
            cand    <= lamp;
            run_cnt <= run_nxt;
            stable  <= stable_nxt;
            if (acc)
                ycnt <= '0;
            else if ((stable == LAMP_Y) && (ycnt < Y_MAX))
                ycnt <= ycnt + YW'(1);
        end
    end

endmodule

// File: rtl/tsc_monitor.sv
// tsc_monitor: conflict and sequence safety monitor for the lamp outputs.
//   clk, rst        clock, async active-high reset
//   nl, sl, el, wl  lamp codes (001 green, 010 yellow, 100 red)
//   fault_clr       leaves FAULT back to ARM; ignored elsewhere
//   armed           high in MON
//   fault           high in FAULT
//   fault_code      sticky causes latched on FAULT entry (see tsc_pkg FC_*)
//   flash           blinks in FAULT, low otherwise
module tsc_monitor
    import tsc_pkg::*;
#(
    parameter int GLITCH_CYC = 2,
    parameter int MIN_YEL    = 3,
    parameter int STUCK_CYC  = 64,
    parameter int ARM_CYC    = 4,
    parameter int FLASH_HALF = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      nl,
    input  logic [2:0]      sl,
    input  logic [2:0]      el,
    input  logic [2:0]      wl,
    input  logic            fault_clr,
    output logic            armed,
    output logic            fault,
    output logic [FC_W-1:0] fault_code,
    output logic            flash
);

    localparam int NUM_APP = 4;
    localparam int AW = $clog2(ARM_CYC) + 1;
    localparam int SW = $clog2(STUCK_CYC) + 1;
    localparam int FW = $clog2(FLASH_HALF) + 1;
    localparam logic [AW-1:0] ARM_MAX  = AW'(ARM_CYC);
    localparam logic [SW-1:0] STK_MAX  = SW'(STUCK_CYC);
    localparam logic [SW-1:0] STK_LAST = SW'(STUCK_CYC - 1);
    localparam logic [FW-1:0] FH_LAST  = FW'(FLASH_HALF - 1);

    mon_state_t state_q, state_d;

    logic [NUM_APP-1:0][2:0] lamp_q, stable_nxt;
    logic [NUM_APP-1:0]      acc, inv, seq_bad, short_yel;
    logic [2:0]              n_active;
    logic                    conflict, any_acc, stk_hit, clr_filt, clean;
    logic [AW-1:0]           arm_cnt, arm_nxt;
    logic [SW-1:0]           stk_cnt;
    logic [FW-1:0]           flash_cnt;
    logic [FC_W-1:0]         det, causes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lamp_q <= {NUM_APP{LAMP_R}};
        else     lamp_q <= {wl, el, sl, nl};
    end

    assign clr_filt = (state_q == ST_FAULT) && fault_clr;

    for (genvar i = 0; i < NUM_APP; i++) begin : g_app
        tsc_lamp_filter #(
            .GLITCH_CYC(GLITCH_CYC),
            .MIN_YEL   (MIN_YEL)
        ) u_filt (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_filt),
            .lamp      (lamp_q[i]),
            .stable_nxt(stable_nxt[i]),
            .acc       (acc[i]),
            .inv       (inv[i]),
            .seq_bad   (seq_bad[i]),
            .short_yel (short_yel[i])
        );
    end

    // Conflict looks at post-accept colours so it fires on the accepting edge
    always_comb begin
        n_active = '0;
        for (int i = 0; i < NUM_APP; i++)
            if (stable_nxt[i] != LAMP_R) n_active = n_active + 3'd1;
    end

    assign conflict = (n_active > 3'd1);
    assign any_acc  = |acc;
    assign stk_hit  = !any_acc && (stk_cnt >= STK_LAST);
    assign clean    = !(|inv) && !conflict;
    assign arm_nxt  = !clean ? '0 : (arm_cnt < ARM_MAX) ? arm_cnt + AW'(1) : arm_cnt;

    always_comb begin
        det               = '0;
        det[FC_INVALID]   = |inv;
        det[FC_CONFLICT]  = conflict;
        det[FC_SEQ]       = |seq_bad;
        det[FC_SHORT_YEL] = |short_yel;
        det[FC_STUCK]     = stk_hit;
    end

    always_comb begin
        state_d = state_q;
        causes  = '0;
        case (state_q)
            ST_ARM:   if (arm_nxt >= ARM_MAX) state_d = ST_MON;
            ST_MON: begin
                causes = det;
                if (|det) state_d = ST_FAULT;
            end
            ST_FAULT: if (fault_clr) state_d = ST_ARM;
            default:  state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARM;
            arm_cnt    <= '0;
            stk_cnt    <= '0;
            fault_code <= '0;
            flash      <= 1'b0;
            flash_cnt  <= '0;
        end else begin
            state_q <= state_d;

            arm_cnt <= ((state_q == ST_ARM) && (state_d == ST_ARM)) ? arm_nxt : '0;

            if (state_q != ST_MON || any_acc) stk_cnt <= '0;
            else if (stk_cnt < STK_MAX)       stk_cnt <= stk_cnt + SW'(1);

            if ((state_q == ST_MON) && (state_d == ST_FAULT)) begin
                fault_code <= causes;
                flash      <= 1'b1;
                flash_cnt  <= '0;
            end else if ((state_q == ST_FAULT) && !fault_clr) begin
                if (flash_cnt == FH_LAST) begin
                    flash     <= ~flash;
                    flash_cnt <= '0;
                end else begin
                    flash_cnt <= flash_cnt + FW'(1);
                end
            end else begin
                if (clr_filt) fault_code <= '0;
                flash     <= 1'b0;
                flash_cnt <= '0;
            end
        end
    end

    assign armed = (state_q == ST_MON);
    assign fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_tsc_monitor.sv
// Scoreboard bench for tsc_monitor: stimulus queues the expected outputs for a
// given cycle number; the monitor compares them on the falling edge of that cycle.
module tb_tsc_monitor;
    import tsc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] nl, sl, el, wl;
    logic       fault_clr;
    logic       armed, fault, flash;
    logic [4:0] fault_code;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       armed;
        logic       fault;
        logic [4:0] code;
        logic       flash;
    } exp_t;

    exp_t  sb[$];
    string sbn[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tsc_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .nl        (nl),
        .sl        (sl),
        .el        (el),
        .wl        (wl),
        .fault_clr (fault_clr),
        .armed     (armed),
        .fault     (fault),
        .fault_code(fault_code),
        .flash     (flash)
    );

    task automatic chk(input string nm, input int dc, input logic a, input logic f,
                       input logic [4:0] c, input logic fl);
        exp_t e;
        e.cyc = cyc + dc; e.armed = a; e.fault = f; e.code = c; e.flash = fl;
        sb.push_back(e);
        sbn.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_app(input int a, input logic [2:0] c);
        nl = LAMP_R; sl = LAMP_R; el = LAMP_R; wl = LAMP_R;
        case (a)
            0:       nl = c;
            1:       sl = c;
            2:       el = c;
            default: wl = c;
        endcase
    endtask

    task automatic clear_and_rearm;
        fault_clr = 1'b1;
        chk("clear", 1, 1'b0, 1'b0, 5'b00000, 1'b0);
        chk("rearm", 8, 1'b1, 1'b0, 5'b00000, 1'b0);
        tick(1);
        fault_clr = 1'b0;
        tick(7);
    endtask

    // Monitor: compares every expectation that falls due this cycle
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                if (sb[i].cyc != cyc || armed !== sb[i].armed || fault !== sb[i].fault ||
                    fault_code !== sb[i].code || flash !== sb[i].flash) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got armed=%b fault=%b code=%b flash=%b, want armed=%b fault=%b code=%b flash=%b (due %0d)",
                             sbn[i], cyc, armed, fault, fault_code, flash,
                             sb[i].armed, sb[i].fault, sb[i].code, sb[i].flash, sb[i].cyc);
                end
                sb.delete(i);
                sbn.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fault_clr = 1'b0;
        set_app(0, LAMP_R);
        @(negedge clk);
        chk("reset_state", 1, 1'b0, 1'b0, 5'b00000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("arm_pending", 3, 1'b0, 1'b0, 5'b00000, 1'b0);
        chk("armed",       6, 1'b1, 1'b0, 5'b00000, 1'b0);
        tick(6);

        // Legal G/Y/R cycling on each approach in turn, ~200 cycles
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 4; a++) begin
                set_app(a, LAMP_G); tick(8);
                chk("legal_g", 1, 1'b1, 1'b0, 5'b00000, 1'b0);
                set_app(a, LAMP_Y); tick(8);
                chk("legal_y", 1, 1'b1, 1'b0, 5'b00000, 1'b0);
                set_app(a, LAMP_R); tick(8);
                chk("legal_r", 1, 1'b1, 1'b0, 5'b00000, 1'b0);
            end
        end

        // Conflict: N and E green together for GLITCH_CYC samples
        nl = LAMP_G; el = LAMP_G;
        chk("conflict_pre",   2, 1'b1, 1'b0, 5'b00000, 1'b0);
        chk("conflict_fault", 3, 1'b0, 1'b1, 5'b00010, 1'b1);
        chk("flash_hold",     6, 1'b0, 1'b1, 5'b00010, 1'b1);
        chk("flash_toggle0",  7, 1'b0, 1'b1, 5'b00010, 1'b0);
        chk("flash_hold0",   10, 1'b0, 1'b1, 5'b00010, 1'b0);
        chk("flash_toggle1", 11, 1'b0, 1'b1, 5'b00010, 1'b1);
        tick(2);
        set_app(0, LAMP_R);
        tick(10);
        clear_and_rearm;

        // fault_clr in MON does nothing
        fault_clr = 1'b1;
        chk("clr_in_mon",  1, 1'b1, 1'b0, 5'b00000, 1'b0);
        chk("clr_in_mon2", 2, 1'b1, 1'b0, 5'b00000, 1'b0);
        tick(1);
        fault_clr = 1'b0;
        tick(1);

        // One-sample invalid glitch is filtered
        nl = 3'b011;
        chk("glitch_a", 3, 1'b1, 1'b0, 5'b00000, 1'b0);
        chk("glitch_b", 4, 1'b1, 1'b0, 5'b00000, 1'b0);
        tick(1);
        nl = LAMP_R;
        tick(4);

        // Bad sequence: G -> R directly
        nl = LAMP_G;
        chk("seq_pre",   6, 1'b1, 1'b0, 5'b00000, 1'b0);
        chk("seq_fault", 7, 1'b0, 1'b1, 5'b00100, 1'b1);
        tick(4);
        nl = LAMP_R;
        tick(5);
        clear_and_rearm;

        // Short yellow: yellow stable for only 2 cycles
        nl = LAMP_G;
        chk("shorty_pre",   12, 1'b1, 1'b0, 5'b00000, 1'b0);
        chk("shorty_fault", 13, 1'b0, 1'b1, 5'b01000, 1'b1);
        tick(8);
        nl = LAMP_Y;
        tick(2);
        nl = LAMP_R;
        tick(5);
        clear_and_rearm;

        // Stuck: one accept (N green at +3) then nothing for STUCK_CYC cycles
        nl = LAMP_G;
        chk("stuck_pre",   66, 1'b1, 1'b0, 5'b00000, 1'b0);
        chk("stuck_fault", 67, 1'b0, 1'b1, 5'b10000, 1'b1);
        tick(70);

        // Asynchronous reset in FAULT (with fault_clr also high): no clock edge needed
        @(posedge clk);
        #2;
        rst = 1'b1; fault_clr = 1'b1;
        chk("async_reset", 0, 1'b0, 1'b0, 5'b00000, 1'b0);
        @(negedge clk);
        fault_clr = 1'b0;
        tick(1);
        rst = 1'b0;
        chk("rearm_after_rst", 6, 1'b1, 1'b0, 5'b00000, 1'b0);
        tick(7);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL pending: %0d expectations never compared, want 0", sb.size());
            errors += sb.size();
            checks += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
